// File: rtl/ohs_boost_pkg.sv
// Shared FSM type and fixed-point helpers for the interleaved boost plant model.
// Build option: define OHS_BOOST_SAT_EN for saturating accumulations (default wraps).
package ohs_boost_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PHASE,
      ST_CAP,
      ST_DONE
   } state_t;

   // Operands arrive sign-extended to 64 bits; callers cast the result back to their width.
   function automatic logic signed [63:0] fxp_mul(
      input logic signed [63:0] a,
      input logic signed [63:0] b,
      input int                 frac
   );
      logic signed [127:0] p;
      p = 128'(a) * 128'(b);
      p = p >>> frac;
      return p[63:0];
   endfunction

`ifdef OHS_BOOST_SAT_EN
   // Clamp a + b to the signed range of a w-bit word.
   function automatic logic signed [63:0] sat_add(
      input logic signed [63:0] a,
      input logic signed [63:0] b,
      input int                 w
   );
      logic signed [64:0] s;
      logic signed [64:0] hi;
      logic signed [64:0] lo;
      s  = 65'(a) + 65'(b);
      hi = (65'sd1 <<< (w - 1)) - 65'sd1;
      lo = -(65'sd1 <<< (w - 1));
      if (s > hi) begin
         s = hi;
      end else if (s < lo) begin
         s = lo;
      end
      return s[63:0];
   endfunction
`endif

endpackage

// File: rtl/ohs_fxp_mac.sv
// Shared fixed-point datapath: diff = base - a*b, result = acc + diff*gain.
// Serves the inductor update in PHASE and the capacitor update in CAP (OHS_BOOST_SAT_EN saturates result).
module ohs_fxp_mac
   import ohs_boost_pkg::*;
#(
   parameter int data_width   = 32,
   parameter int data_decimal = 22
) (
   input  logic signed [data_width-1:0] base,
   input  logic signed [data_width-1:0] mul_a,
   input  logic signed [data_width-1:0] mul_b,
   input  logic signed [data_width-1:0] acc,
   input  logic signed [data_width-1:0] gain,
   output logic signed [data_width-1:0] prod,
   output logic signed [data_width-1:0] diff,
   output logic signed [data_width-1:0] result
);

   logic signed [data_width-1:0] term;

   always_comb begin
      prod = data_width'(fxp_mul(64'(mul_a), 64'(mul_b), data_decimal));
      diff = base - prod;
      term = data_width'(fxp_mul(64'(diff), 64'(gain), data_decimal));
`ifdef OHS_BOOST_SAT_EN
      result = data_width'(sat_add(64'(acc), 64'(term), data_width));
`else
      result = acc + term;
`endif
   end

endmodule

// File: rtl/ohs_boost_interleaved_l2.sv
// N-phase interleaved boost converter plant: one phase per cycle, then the shared capacitor.
// Build option: OHS_BOOST_SAT_EN makes iL, isum and vC accumulations saturate.
module ohs_boost_interleaved_l2
   import ohs_boost_pkg::*;
#(
   parameter int n_phases     = 2,
   parameter int data_width   = 32,
   parameter int data_decimal = 22
) (
   input  logic                           aclk,
   input  logic                           resetn,
   input  logic                           ce,
   input  logic                           dcm_en,
   input  logic signed [data_width-1:0]   kL,
   input  logic signed [data_width-1:0]   kRL,
   input  logic signed [data_width-1:0]   kC,
   input  logic signed [data_width-1:0]   kR,
   input  logic signed [data_width-1:0]   vdc,
   input  logic [n_phases-1:0]            s_pwm,
   output logic [n_phases*data_width-1:0] iL,
   output logic signed [data_width-1:0]   vC,
   output logic signed [data_width-1:0]   iC,
   output logic signed [data_width-1:0]   iLoad,
   output logic                           busy,
   output logic                           step_done,
   output logic                           overrun
);

   localparam int            KW     = (n_phases > 1) ? $clog2(n_phases) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(n_phases - 1);

   state_t                       state_reg, state_next;
   logic [KW-1:0]                k_reg;
   logic [n_phases-1:0]          pwm_q_reg;
   logic signed [data_width-1:0] vc_q_reg;
   logic signed [data_width-1:0] isum_reg;
   logic signed [data_width-1:0] vc_reg;
   logic signed [data_width-1:0] ic_reg;
   logic signed [data_width-1:0] iload_reg;
   logic signed [data_width-1:0] il_reg [n_phases];
   logic                         overrun_reg;

   logic signed [data_width-1:0] mac_base, mac_a, mac_b, mac_acc, mac_gain;
   logic signed [data_width-1:0] mac_prod, mac_diff, mac_result;
   logic signed [data_width-1:0] il_cur, il_new, isum_add, isum_next;
   logic                         open_k;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (ce) state_next = ST_PHASE;
         ST_PHASE: if (k_reg == K_LAST) state_next = ST_CAP;
         ST_CAP:   state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Phases and the capacitor share one MAC; all of them use the pre-step vC snapshot.
   always_comb begin
      il_cur = il_reg[k_reg];
      open_k = ~pwm_q_reg[k_reg];
      if (state_reg == ST_CAP) begin
         mac_base = isum_reg;
         mac_a    = vc_q_reg;
         mac_b    = kR;
         mac_acc  = vc_q_reg;
         mac_gain = kC;
      end else begin
         mac_base = open_k ? vdc - vc_q_reg : vdc;
         mac_a    = il_cur;
         mac_b    = kRL;
         mac_acc  = il_cur;
         mac_gain = kL;
      end
   end

   ohs_fxp_mac #(
      .data_width   (data_width),
      .data_decimal (data_decimal)
   ) u_mac (
      .base   (mac_base),
      .mul_a  (mac_a),
      .mul_b  (mac_b),
      .acc    (mac_acc),
      .gain   (mac_gain),
      .prod   (mac_prod),
      .diff   (mac_diff),
      .result (mac_result)
   );

   // With the switch open the diode may block reverse current; only open phases feed the cap.
   always_comb begin
      il_new = mac_result;
      if (dcm_en && open_k && mac_result[data_width-1]) begin
         il_new = '0;
      end
      isum_add = open_k ? il_new : '0;
`ifdef OHS_BOOST_SAT_EN
      isum_next = data_width'(sat_add(64'(isum_reg), 64'(isum_add), data_width));
`else
      isum_next = isum_reg + isum_add;
`endif
   end

   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         state_reg   <= ST_IDLE;
         k_reg       <= '0;
         pwm_q_reg   <= '0;
         vc_q_reg    <= '0;
         isum_reg    <= '0;
         vc_reg      <= '0;
         ic_reg      <= '0;
         iload_reg   <= '0;
         overrun_reg <= 1'b0;
         for (int i = 0; i < n_phases; i++) begin
            il_reg[i] <= '0;
         end
      end else begin
         state_reg <= state_next;
         if (ce && state_reg != ST_IDLE) begin
            overrun_reg <= 1'b1;
         end
         case (state_reg)
            ST_IDLE: begin
               if (ce) begin
                  pwm_q_reg <= s_pwm;
                  vc_q_reg  <= vc_reg;
                  isum_reg  <= '0;
                  k_reg     <= '0;
               end
            end
            ST_PHASE: begin
               il_reg[k_reg] <= il_new;
               isum_reg      <= isum_next;
               k_reg         <= k_reg + KW'(1);
            end
            ST_CAP: begin
               iload_reg <= mac_prod;
               ic_reg    <= mac_diff;
               vc_reg    <= mac_result;
            end
            default: ;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < n_phases; gi++) begin : g_il_out
         assign iL[gi*data_width +: data_width] = il_reg[gi];
      end
   endgenerate

   assign vC        = vc_reg;
   assign iC        = ic_reg;
   assign iLoad     = iload_reg;
   assign overrun   = overrun_reg;
   assign busy      = (state_reg != ST_IDLE);
   assign step_done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_ohs_boost_interleaved_l2.sv
// Self-checking bench for ohs_boost_interleaved_l2: vector table, corner sequences, random steps vs model.
// Honours OHS_BOOST_SAT_EN so expectations follow the build option.
module tb_ohs_boost_interleaved_l2;

   localparam int          NP   = 2;
   localparam int          W    = 32;
   localparam int          DEC  = 22;
   localparam logic [31:0] ONE  = 32'h0040_0000;
   localparam logic [31:0] QTR  = 32'h0010_0000;
   localparam logic [31:0] HALF = 32'h0020_0000;

   logic          aclk   = 1'b0;
   logic          resetn = 1'b0;
   logic          ce     = 1'b0;
   logic          dcm_en = 1'b0;
   logic [W-1:0]  kL = '0, kRL = '0, kC = '0, kR = '0, vdc = '0;
   logic [NP-1:0] s_pwm = '0;
   logic [NP*W-1:0] iL;
   logic [W-1:0]  vC, iC, iLoad;
   logic          busy, step_done, overrun;

   int n_vec = 0;
   int n_err = 0;

   ohs_boost_interleaved_l2 #(
      .n_phases     (NP),
      .data_width   (W),
      .data_decimal (DEC)
   ) dut (
      .aclk      (aclk),
      .resetn    (resetn),
      .ce        (ce),
      .dcm_en    (dcm_en),
      .kL        (kL),
      .kRL       (kRL),
      .kC        (kC),
      .kR        (kR),
      .vdc       (vdc),
      .s_pwm     (s_pwm),
      .iL        (iL),
      .vC        (vC),
      .iC        (iC),
      .iLoad     (iLoad),
      .busy      (busy),
      .step_done (step_done),
      .overrun   (overrun)
   );

   always #5 aclk = ~aclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural reference ----------------
   logic [31:0] m_il [NP];
   logic [31:0] m_vc, m_ic, m_iload;

   function automatic logic [31:0] fx_mul(input logic [31:0] a, input logic [31:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      p = p >>> DEC;
      return p[31:0];
   endfunction

   function automatic logic [31:0] fx_acc(input logic [31:0] a, input logic [31:0] b);
      longint s;
      s = longint'($signed(a)) + longint'($signed(b));
`ifdef OHS_BOOST_SAT_EN
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
      return s[31:0];
   endfunction

   task automatic model_step(input logic [NP-1:0] pwm, input bit dcm);
      logic [31:0] vcq, isum, vl, inew;
      vcq  = m_vc;
      isum = '0;
      for (int k = 0; k < NP; k++) begin
         vl   = vdc - fx_mul(m_il[k], kRL) - (pwm[k] ? 32'd0 : vcq);
         inew = fx_acc(m_il[k], fx_mul(vl, kL));
         if (dcm && !pwm[k] && inew[31]) inew = '0;
         m_il[k] = inew;
         if (!pwm[k]) isum = fx_acc(isum, inew);
      end
      m_iload = fx_mul(vcq, kR);
      m_ic    = isum - m_iload;
      m_vc    = fx_acc(vcq, fx_mul(m_ic, kC));
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      ce     = 1'b0;
      resetn = 1'b0;
      repeat (2) @(negedge aclk);
      resetn = 1'b1;
      @(negedge aclk);
   endtask

   // One accepted step; lat counts cycles from the ce cycle to step_done.
   task automatic run_step(input bit scramble, output int lat);
      @(negedge aclk);
      ce = 1'b1;
      @(negedge aclk);
      ce  = 1'b0;
      lat = 1;
      check("busy_after_ce", {31'd0, busy}, 32'd1);
      if (scramble) s_pwm = ~s_pwm;
      while (step_done !== 1'b1 && lat < 40) begin
         @(negedge aclk);
         lat++;
      end
      @(negedge aclk);
      check("done_one_cycle", {30'd0, step_done, busy}, 32'd0);
   endtask

   typedef struct {
      bit          rst;
      logic [31:0] kl, krl, kc, kr, vdc;
      logic [1:0]  pwm;
      bit          dcm;
      logic [31:0] e_il0, e_il1, e_vc, e_ic, e_iload;
   } vec_t;

   vec_t tbl [12];

   initial begin
      int lat;
      int pulses;
      logic [31:0] exp6 [3];
      logic [NP-1:0] pwm_r;

      // rst, kL, kRL, kC, kR, vdc, pwm, dcm -> iL0, iL1, vC, iC, iLoad
      tbl[0]  = '{1'b1, QTR,   32'd0, 32'd0,        32'd0, ONE, 2'b11, 1'b0, QTR, QTR, 32'd0, 32'd0, 32'd0};
      tbl[1]  = '{1'b0, 32'd0, 32'd0, 32'h0100_0000, 32'd0, ONE, 2'b00, 1'b0, QTR, QTR, 32'h0080_0000, HALF, 32'd0};
      tbl[2]  = '{1'b0, QTR,   32'd0, QTR,          32'd0, ONE, 2'b00, 1'b0, 32'd0, 32'd0, 32'h0080_0000, 32'd0, 32'd0};
      tbl[3]  = tbl[0];
      tbl[4]  = tbl[1];
      tbl[5]  = '{1'b0, HALF,  32'd0, QTR,          32'd0, ONE, 2'b00, 1'b1, 32'd0, 32'd0, 32'h0080_0000, 32'd0, 32'd0};
      tbl[6]  = tbl[0];
      tbl[7]  = tbl[1];
      tbl[8]  = '{1'b0, HALF,  32'd0, QTR,          32'd0, ONE, 2'b00, 1'b0, 32'hFFF0_0000, 32'hFFF0_0000, 32'h0078_0000, 32'hFFE0_0000, 32'd0};
      tbl[9]  = '{1'b0, QTR,   32'd0, QTR,          HALF,  ONE, 2'b11, 1'b0, 32'd0, 32'd0, 32'h0069_0000, 32'hFFC4_0000, 32'h003C_0000};
      tbl[10] = '{1'b0, QTR,   HALF,  QTR,          32'd0, ONE, 2'b01, 1'b0, QTR, 32'hFFF5_C000, 32'h0066_7000, 32'hFFF5_C000, 32'd0};
      tbl[11] = '{1'b0, QTR,   HALF,  32'd0,        32'd0, ONE, 2'b00, 1'b0, 32'h0004_6400, 32'hFFED_6C00, 32'h0066_7000, 32'hFFF1_D000, 32'd0};

      // Reset state
      do_reset();
      check("rst_iL0", iL[31:0], 32'd0);
      check("rst_iL1", iL[63:32], 32'd0);
      check("rst_vC", vC, 32'd0);
      check("rst_flags", {29'd0, busy, step_done, overrun}, 32'd0);

      // Table-driven steps
      for (int i = 0; i < 12; i++) begin
         if (tbl[i].rst) do_reset();
         kL = tbl[i].kl; kRL = tbl[i].krl; kC = tbl[i].kc; kR = tbl[i].kr;
         vdc = tbl[i].vdc; s_pwm = tbl[i].pwm; dcm_en = tbl[i].dcm;
         run_step(1'b0, lat);
         check("tbl_latency", lat, NP + 2);
         check("tbl_iL0", iL[31:0], tbl[i].e_il0);
         check("tbl_iL1", iL[63:32], tbl[i].e_il1);
         check("tbl_vC", vC, tbl[i].e_vc);
         check("tbl_iC", iC, tbl[i].e_ic);
         check("tbl_iLoad", iLoad, tbl[i].e_iload);
         $display("vec %0d: iL0=%h iL1=%h vC=%h iC=%h iLoad=%h lat=%0d",
                  i, iL[31:0], iL[63:32], vC, iC, iLoad, lat);
      end

      // Large input voltage: saturate or wrap depending on build
      exp6[0] = 32'h7000_0000;
`ifdef OHS_BOOST_SAT_EN
      exp6[1] = 32'h7FFF_FFFF;
      exp6[2] = 32'h7FFF_FFFF;
`else
      exp6[1] = 32'hE000_0000;
      exp6[2] = 32'h5000_0000;
`endif
      do_reset();
      kL = ONE; kRL = '0; kC = '0; kR = '0; vdc = 32'h7000_0000; s_pwm = 2'b11; dcm_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         run_step(1'b0, lat);
         check("big_iL0", iL[31:0], exp6[i]);
         check("big_iL1", iL[63:32], exp6[i]);
         $display("big step %0d: iL0=%h iL1=%h", i, iL[31:0], iL[63:32]);
      end

      // ce two cycles into a step: flagged, ignored, single step_done
      do_reset();
      kL = QTR; kRL = '0; kC = '0; kR = '0; vdc = ONE; s_pwm = 2'b11; dcm_en = 1'b0;
      check("ovr_clear", {31'd0, overrun}, 32'd0);
      @(negedge aclk); ce = 1'b1;
      @(negedge aclk); ce = 1'b0;
      @(negedge aclk); ce = 1'b1;
      @(negedge aclk); ce = 1'b0;
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         if (step_done) pulses++;
         @(negedge aclk);
      end
      check("ovr_pulses", pulses, 32'd1);
      check("ovr_flag", {31'd0, overrun}, 32'd1);
      check("ovr_iL0", iL[31:0], QTR);
      $display("overrun seq: pulses=%0d overrun=%b iL0=%h", pulses, overrun, iL[31:0]);

      // Reset in the middle of PHASE k=1
      kL = '0; kC = 32'h0100_0000; s_pwm = 2'b00;
      run_step(1'b0, lat);
      check("pre_rst_vC", vC, 32'h0080_0000);
      kL = QTR; kC = QTR;
      @(negedge aclk); ce = 1'b1;
      @(negedge aclk); ce = 1'b0;
      @(negedge aclk);
      check("mid_busy", {31'd0, busy}, 32'd1);
      resetn = 1'b0;
      #1;
      check("mid_rst_iL", iL[31:0] | iL[63:32], 32'd0);
      check("mid_rst_vC", vC, 32'd0);
      check("mid_rst_iC_iLoad", iC | iLoad, 32'd0);
      check("mid_rst_flags", {29'd0, busy, step_done, overrun}, 32'd0);
      $display("async reset mid-step: busy=%b overrun=%b vC=%h", busy, overrun, vC);
      @(negedge aclk); @(negedge aclk);
      resetn = 1'b1;
      @(negedge aclk);

      // Random steps against the reference model (s_pwm scrambled mid-step)
      for (int k = 0; k < NP; k++) m_il[k] = '0;
      m_vc = '0;
      for (int i = 0; i < 40; i++) begin
         kL  = $urandom_range(0, 32'h0020_0000);
         kRL = $urandom_range(0, 32'h0010_0000);
         kC  = $urandom_range(0, 32'h0020_0000);
         kR  = $urandom_range(0, 32'h0010_0000);
         vdc = (i % 8 == 7) ? $urandom : ($urandom_range(0, 32'h0400_0000) - 32'h0100_0000);
         pwm_r  = NP'($urandom_range(0, 3));
         s_pwm  = pwm_r;
         dcm_en = 1'($urandom_range(0, 1));
         model_step(pwm_r, dcm_en);
         run_step(1'b1, lat);
         check("rnd_latency", lat, NP + 2);
         check("rnd_iL0", iL[31:0], m_il[0]);
         check("rnd_iL1", iL[63:32], m_il[1]);
         check("rnd_vC", vC, m_vc);
         check("rnd_iC", iC, m_ic);
         check("rnd_iLoad", iLoad, m_iload);
         $display("rnd %0d: pwm=%b dcm=%b iL0=%h iL1=%h vC=%h", i, pwm_r, dcm_en, iL[31:0], iL[63:32], vC);
      end
      check("rnd_no_overrun", {31'd0, overrun}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
